// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch unit: byte-wise fetch, operand assembly and issue handshake
//
// Ports:
//   clk, rst_n          clock (rising edge) and asynchronous active-low reset
//   start, start_addr   begin fetching at start_addr (honoured only in IDLE/HALT)
//   mem_we              instruction memory busy writing; fetch stalls in FETCH_* states
//   r_addr, r_instr     read address out; registered read data back one cycle later
//   opcode, operand     issued instruction; operand is 0 for single-byte instructions
//   instr_valid         opcode/operand/illegal valid; held until instr_ready
//   instr_ready         core accepts the instruction
//   jump_en, jump_addr  branch request, sampled only on the issue handshake
//   illegal             issued opcode is above 47
//   halted              ENDOP has been accepted
//   pc                  address of the next byte to fetch

module instr_fetch #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] r_addr,
    input  logic [DATA_WIDTH-1:0] r_instr,
    output logic [DATA_WIDTH-1:0] opcode,
    output logic [DATA_WIDTH-1:0] operand,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    input  logic                  jump_en,
    input  logic [ADDR_WIDTH-1:0] jump_addr,
    output logic                  illegal,
    output logic                  halted,
    output logic [ADDR_WIDTH-1:0] pc
);

    localparam logic [DATA_WIDTH-1:0] OP_LDACI   = DATA_WIDTH'(0);
    localparam logic [DATA_WIDTH-1:0] OP_STACI   = DATA_WIDTH'(13);
    localparam logic [DATA_WIDTH-1:0] OP_JPNZ    = DATA_WIDTH'(27);
    localparam logic [DATA_WIDTH-1:0] OP_ENDOP   = DATA_WIDTH'(28);
    localparam logic [DATA_WIDTH-1:0] OP_MAX_LEG = DATA_WIDTH'(47);

    typedef enum logic [2:0] {
        IDLE,
        FETCH_OP,
        WAIT_OP,
        FETCH_ARG,
        WAIT_ARG,
        ISSUE,
        HALT
    } state_t;

    state_t                  state, state_next;
    logic [ADDR_WIDTH-1:0]   pc_q, pc_next;
    logic [DATA_WIDTH-1:0]   opcode_q, opcode_next;
    logic [DATA_WIDTH-1:0]   operand_q, operand_next;
    logic                    halted_q, halted_next;
    logic                    two_byte;

    // Only these opcodes carry an immediate byte.
    assign two_byte = (r_instr == OP_LDACI) || (r_instr == OP_STACI) || (r_instr == OP_JPNZ);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pc_q      <= '0;
            opcode_q  <= '0;
            operand_q <= '0;
            halted_q  <= 1'b0;
        end else begin
            state     <= state_next;
            pc_q      <= pc_next;
            opcode_q  <= opcode_next;
            operand_q <= operand_next;
            halted_q  <= halted_next;
        end
    end

    always_comb begin
        state_next   = state;
        pc_next      = pc_q;
        opcode_next  = opcode_q;
        operand_next = operand_q;
        halted_next  = halted_q;
        case (state)
            IDLE, HALT: begin
                if (start) begin
                    pc_next     = start_addr;
                    halted_next = 1'b0;
                    state_next  = FETCH_OP;
                end
            end
            // The memory only samples r_addr when it is not being written,
            // so the read is launched on the first cycle with mem_we low.
            FETCH_OP: begin
                if (!mem_we) state_next = WAIT_OP;
            end
            // Read data is already registered here; mem_we no longer matters.
            WAIT_OP: begin
                opcode_next = r_instr;
                pc_next     = pc_q + ADDR_WIDTH'(1);
                if (two_byte) begin
                    state_next = FETCH_ARG;
                end else begin
                    operand_next = '0;
                    state_next   = ISSUE;
                end
            end
            FETCH_ARG: begin
                if (!mem_we) state_next = WAIT_ARG;
            end
            WAIT_ARG: begin
                operand_next = r_instr;
                pc_next      = pc_q + ADDR_WIDTH'(1);
                state_next   = ISSUE;
            end
            ISSUE: begin
                if (instr_ready) begin
                    if (opcode_q == OP_ENDOP) begin
                        halted_next = 1'b1;
                        state_next  = HALT;
                    end else begin
                        if (jump_en) pc_next = jump_addr;
                        state_next = FETCH_OP;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign pc          = pc_q;
    assign r_addr      = pc_q;
    assign opcode      = opcode_q;
    assign operand     = operand_q;
    assign halted      = halted_q;
    assign instr_valid = (state == ISSUE);
    assign illegal     = instr_valid && (opcode_q > OP_MAX_LEG);

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed self-checking bench for instr_fetch

module tb_instr_fetch;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] start_addr;
    logic       mem_we;
    logic [7:0] r_addr;
    logic [7:0] r_instr;
    logic [7:0] opcode;
    logic [7:0] operand;
    logic       instr_valid;
    logic       instr_ready;
    logic       jump_en;
    logic [7:0] jump_addr;
    logic       illegal;
    logic       halted;
    logic [7:0] pc;

    logic [7:0] mem [256];

    int n_cmp = 0;
    int n_bad = 0;

    instr_fetch #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .start_addr  (start_addr),
        .mem_we      (mem_we),
        .r_addr      (r_addr),
        .r_instr     (r_instr),
        .opcode      (opcode),
        .operand     (operand),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .jump_en     (jump_en),
        .jump_addr   (jump_addr),
        .illegal     (illegal),
        .halted      (halted),
        .pc          (pc)
    );

    always #5 clk = ~clk;

    // Registered instruction memory: no read while a write is in progress.
    always @(posedge clk) begin
        if (!mem_we) r_instr <= mem[r_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_at(input logic [7:0] a);
        start      = 1'b1;
        start_addr = a;
        step();
        start      = 1'b0;
    endtask

    // Called one cycle after the start/handshake edge; lat is cycles since that event.
    task automatic wait_valid(output int lat);
        int cnt;
        cnt = 0;
        while (!instr_valid && cnt < 20) begin
            step();
            cnt++;
        end
        lat = cnt + 1;
        if (!instr_valid) check_eq("valid_timeout", 32'(instr_valid), 1);
    endtask

    task automatic expect_issue(input string tag, input int exp_lat,
                                input logic [7:0] op, input logic [7:0] arg);
        int lat;
        wait_valid(lat);
        check_eq({tag, "_lat"}, lat, exp_lat);
        check_eq({tag, "_op"}, opcode, op);
        check_eq({tag, "_arg"}, operand, arg);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_raddr"}, r_addr, 0);
        check_eq({tag, "_pc"}, pc, 0);
        check_eq({tag, "_op"}, opcode, 0);
        check_eq({tag, "_arg"}, operand, 0);
        check_eq({tag, "_valid"}, instr_valid, 0);
        check_eq({tag, "_illegal"}, illegal, 0);
        check_eq({tag, "_halted"}, halted, 0);
    endtask

    initial begin
        int lat;
        for (int i = 0; i < 256; i++) mem[i] = 8'd28;
        rst_n = 1'b0; start = 1'b0; start_addr = '0; mem_we = 1'b0;
        instr_ready = 1'b1; jump_en = 1'b0; jump_addr = '0;
        step(); step();
        check_all_zero("reset");
        rst_n = 1'b1;
        step(); step();
        check_eq("idle_no_start_valid", instr_valid, 0);
        check_eq("idle_no_start_pc", pc, 0);

        // Single-byte sequence ending in ENDOP
        mem[0] = 8'd24; mem[1] = 8'd26; mem[2] = 8'd28;
        start_at(8'd0);
        expect_issue("t1_i0", 3, 8'd24, 8'd0);
        step();
        expect_issue("t1_i1", 3, 8'd26, 8'd0);
        step();
        expect_issue("t1_i2", 3, 8'd28, 8'd0);
        step();
        check_eq("t1_halted", halted, 1);
        check_eq("t1_pc", pc, 3);
        check_eq("t1_valid", instr_valid, 0);

        // Two-byte instructions, restart from HALT
        mem[0] = 8'd0; mem[1] = 8'd9; mem[2] = 8'd13; mem[3] = 8'd1; mem[4] = 8'd28;
        start_at(8'd0);
        check_eq("t2_halted_clr", halted, 0);
        expect_issue("t2_i0", 5, 8'd0, 8'd9);
        step();
        expect_issue("t2_i1", 5, 8'd13, 8'd1);
        step();
        expect_issue("t2_i2", 3, 8'd28, 8'd0);
        step();

        // Jump taken on handshake
        mem[61] = 8'd27; mem[62] = 8'd27;
        start_at(8'd61);
        expect_issue("t3_jp", 5, 8'd27, 8'd27);
        jump_en = 1'b1; jump_addr = 8'd27;
        step();
        jump_en = 1'b0;
        check_eq("t3_raddr", r_addr, 27);
        expect_issue("t3_end", 3, 8'd28, 8'd0);
        step();

        // Jump not taken
        start_at(8'd61);
        expect_issue("t4_jp", 5, 8'd27, 8'd27);
        step();
        check_eq("t4_raddr", r_addr, 63);
        expect_issue("t4_end", 3, 8'd28, 8'd0);
        step();

        // Backpressure then memory-write stall
        mem[100] = 8'd24; mem[101] = 8'd26;
        instr_ready = 1'b0;
        start_at(8'd100);
        expect_issue("t5_i0", 3, 8'd24, 8'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("t5_hold_valid", instr_valid, 1);
            check_eq("t5_hold_op", opcode, 24);
        end
        instr_ready = 1'b1;
        step();
        mem_we = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            check_eq("t5_stall_raddr", r_addr, 101);
            check_eq("t5_stall_valid", instr_valid, 0);
        end
        mem_we = 1'b0;
        wait_valid(lat);
        check_eq("t5_stall_lat", lat + 2, 5);
        check_eq("t5_i1_op", opcode, 26);
        step();
        expect_issue("t5_end", 3, 8'd28, 8'd0);
        step();

        // PC wrap with operand at address 0
        mem[255] = 8'd0; mem[0] = 8'd7; mem[1] = 8'd28;
        start_at(8'd255);
        expect_issue("t6_wrap", 5, 8'd0, 8'd7);
        check_eq("t6_pc", pc, 1);
        step();
        expect_issue("t6_end", 3, 8'd28, 8'd0);
        step();

        // Illegal opcode
        mem[0] = 8'd50; mem[1] = 8'd28;
        start_at(8'd0);
        expect_issue("t7_ill", 3, 8'd50, 8'd0);
        check_eq("t7_illegal", illegal, 1);
        step();
        check_eq("t7_raddr", r_addr, 1);
        expect_issue("t7_end", 3, 8'd28, 8'd0);
        check_eq("t7_illegal_end", illegal, 0);
        step();

        // start and jump_en ignored without a handshake
        mem[10] = 8'd24; mem[11] = 8'd28;
        start_at(8'd10);
        expect_issue("t8_i0", 3, 8'd24, 8'd0);
        instr_ready = 1'b0; start = 1'b1; start_addr = 8'd200;
        jump_en = 1'b1; jump_addr = 8'd99;
        step();
        check_eq("t8_valid", instr_valid, 1);
        check_eq("t8_op", opcode, 24);
        check_eq("t8_pc", pc, 11);
        start = 1'b0; jump_en = 1'b0; instr_ready = 1'b1;
        step();
        check_eq("t8_raddr", r_addr, 11);
        expect_issue("t8_end", 3, 8'd28, 8'd0);
        step();

        // Reset in WAIT_ARG
        mem[5] = 8'd13; mem[6] = 8'd9;
        start_at(8'd5);
        step(); step(); step();
        check_eq("t9_pre_pc", pc, 6);
        check_eq("t9_pre_op", opcode, 13);
        rst_n = 1'b0;
        #1;
        check_all_zero("t9_rst");
        step();
        rst_n = 1'b1;
        step(); step(); step();
        check_eq("t9_idle_valid", instr_valid, 0);
        check_eq("t9_idle_pc", pc, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 8, meaning the instruction byte width.
REQ-002 The module SHALL have parameter ADDR_WIDTH, default 8, meaning the instruction memory address width.
REQ-003 The module SHALL have one clock and an asynchronous, active-low reset.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 The module SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The module SHALL have port start, input, 1 bit: begin fetching at start_addr; honoured only in IDLE or HALT.
REQ-007 The module SHALL have port start_addr, input, ADDR_WIDTH bits: initial program counter.
REQ-008 The module SHALL have port mem_we, input, 1 bit: instruction memory write in progress, so memory does not read this cycle.
REQ-009 The module SHALL have port r_addr, output, ADDR_WIDTH bits: read address to instruction memory.
REQ-010 The module SHALL have port r_instr, input, DATA_WIDTH bits: registered read data, valid one cycle after r_addr is sampled.
REQ-011 The module SHALL have port opcode, output, DATA_WIDTH bits: current instruction opcode.
REQ-012 The module SHALL have port operand, output, DATA_WIDTH bits: immediate byte; 0 for single-byte instructions.
REQ-013 The module SHALL have port instr_valid, output, 1 bit: opcode/operand valid.
REQ-014 The module SHALL have port instr_ready, input, 1 bit: core accepts the instruction.
REQ-015 The module SHALL have port jump_en, input, 1 bit: take a branch; sampled only on handshake.
REQ-016 The module SHALL have port jump_addr, input, ADDR_WIDTH bits: branch target.
REQ-017 The module SHALL have port illegal, output, 1 bit: issued opcode > 47; valid with instr_valid.
REQ-018 The module SHALL have port halted, output, 1 bit: ENDOP has been accepted.
REQ-019 The module SHALL have port pc, output, ADDR_WIDTH bits: address of the next byte to fetch.

Function
REQ-020 The module SHALL implement the states IDLE, FETCH_OP, WAIT_OP, FETCH_ARG, WAIT_ARG, ISSUE and HALT.
REQ-021 In IDLE or HALT, start=1 SHALL load pc<=start_addr, clear halted and go to FETCH_OP.
REQ-022 FETCH_OP SHALL drive r_addr=pc; if mem_we=0, go to WAIT_OP, else remain (stall).
REQ-023 WAIT_OP SHALL capture opcode<=r_instr and pc<=pc+1.
REQ-024 From WAIT_OP, opcode 0 (LDACI), 13 (STACI) or 27 (JPNZ) SHALL go to FETCH_ARG; any other opcode SHALL go to ISSUE with operand<=0.
REQ-025 FETCH_ARG SHALL drive r_addr=pc and stall while mem_we=1, exactly as in FETCH_OP.
REQ-026 WAIT_ARG SHALL capture operand<=r_instr, set pc<=pc+1 and go to ISSUE.
REQ-027 ISSUE SHALL assert instr_valid; opcode, operand and illegal SHALL stay stable until instr_valid & instr_ready.
REQ-028 On handshake with opcode 28 (ENDOP), the module SHALL go to HALT and set halted=1.
REQ-029 On handshake with jump_en=1, the module SHALL set pc<=jump_addr and go to FETCH_OP.
REQ-030 On any other handshake, the module SHALL go to FETCH_OP with pc unchanged.
REQ-031 jump_en SHALL be ignored when no handshake occurs.
REQ-032 Latency from start, with no stalls and instr_ready=1: instr_valid SHALL rise 3 cycles after start for single-byte instructions and 5 cycles after start for two-byte instructions.
REQ-033 Steady-state throughput SHALL be one single-byte instruction per 3 cycles.
REQ-034 pc SHALL wrap modulo 2**ADDR_WIDTH, so 255+1=0 with no flag.
REQ-035 An operand byte at address 0 after wrap SHALL be fetched normally.
REQ-036 An illegal opcode (> 47) SHALL be issued as single-byte with illegal=1, and fetch SHALL continue.
REQ-037 start SHALL be ignored outside IDLE and HALT.
REQ-038 In WAIT_OP and WAIT_ARG, mem_we SHALL be ignored, because the data was already registered.
REQ-039 r_addr SHALL equal pc in all states.

Reset
REQ-040 rst_n=0 SHALL immediately force state IDLE and pc, r_addr, opcode, operand=0.
REQ-041 rst_n=0 SHALL immediately force instr_valid, illegal and halted=0.
REQ-042 Reset asserted mid-fetch or mid-issue SHALL abandon the instruction without a handshake.
REQ-043 After release, the module SHALL remain in IDLE until start.

Verification
REQ-044 Memory {0:24 (CLRAC), 1:26 (INAC), 2:28 (ENDOP)}, start_addr=0, instr_ready=1 -> the bench SHALL see issue sequence 24, 26, 28, each operand=0; first instr_valid 3 cycles after start; halted=1; pc=3.
REQ-045 Memory {0:0, 1:9, 2:13, 3:1} -> the bench SHALL see (opcode 0, operand 9) then (opcode 13, operand 1); each instr_valid 5 cycles after the previous handshake or start.
REQ-046 Memory {61:27, 62:27} with jump_en=1 and jump_addr=27 on handshake -> the next r_addr SHALL be 27.
REQ-047 Same memory as REQ-046 with jump_en=0 -> fetch SHALL continue at 63.
REQ-048 instr_ready held 0 for 4 cycles, then mem_we=1 for 2 cycles during FETCH_OP -> opcode SHALL stay stable, fetch SHALL be delayed exactly 2 cycles, and no byte SHALL be skipped.
REQ-049 start_addr=255, memory {255:0, 0:7} -> the module SHALL issue opcode 0 with operand 7, and pc SHALL be 1.
REQ-050 Opcode 50 at address 0 -> illegal=1 during ISSUE, and the next fetch SHALL come from address 1.
REQ-051 rst_n pulsed low in WAIT_ARG -> all outputs SHALL be 0 and the state IDLE.
REQ-052 start during ISSUE -> start SHALL be ignored.
